// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-port SRAM between instruction fetch and the
// data stage. Each grant runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority on conflict);
// when undefined, the data stage always wins a conflict.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        freeze,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             owner_data;
    logic             owner_write;
    logic             data_req;
    logic             any_req;
    logic             grant_data;
    logic             grant_write;
    logic             unused_addr_bits;

`ifdef ARB_ROUND_ROBIN_EN
    logic             prio_data;
    logic             conflict;
`endif

    assign data_req = mem_r_en | mem_w_en;
    assign any_req  = if_req | data_req;

    // Byte-offset bits never reach the word-addressed SRAM.
    assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

    // Stall the pipeline while any requester is still waiting for its ready.
    assign freeze = (if_req & ~if_ready) | (data_req & ~mem_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_next  = state;
        grant_data  = data_req;
`ifdef ARB_ROUND_ROBIN_EN
        grant_data  = data_req & (~if_req | prio_data);
`endif
        grant_write = grant_data & mem_w_en;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant latching, SRAM strobes, read-data capture and ready pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            owner_data  <= 1'b0;
            owner_write <= 1'b0;
            sram_en     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
        end else begin
            sram_en   <= (state_next == ACCESS);
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    sram_we <= grant_write;
                    if (any_req) begin
                        owner_data  <= grant_data;
                        owner_write <= grant_write;
                        sram_addr   <= grant_data ? mem_addr[31:2] : if_addr[31:2];
                        if (grant_write) begin
                            sram_wdata <= mem_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (state_next == DONE) begin
                        sram_we   <= 1'b0;
                        if_ready  <= ~owner_data;
                        mem_ready <= owner_data;
                        if (!owner_data) begin
                            if_rdata <= sram_rdata;
                        end else if (!owner_write) begin
                            mem_rdata <= sram_rdata;
                        end
                    end
                end
                default: begin
                    sram_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Priority pointer: after a completed conflict grant, the other side wins next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_data <= 1'b1;
            conflict  <= 1'b0;
        end else if (state == IDLE && any_req) begin
            conflict <= if_req & data_req;
        end else if (state == DONE && conflict) begin
            prio_data <= ~owner_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level timeline model of the arbiter, checked
// cycle by cycle with directed and randomized requests.
module tb_mem_arbiter;

    localparam int unsigned W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        freeze;
    logic        sram_en;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
    bit          rr_data_wins;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .freeze     (freeze),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] byte_addr);
        logic [29:0] wa;
        wa = byte_addr[31:2];
        return {wa[15:0] ^ 16'hA5A5, ~wa[15:0]};
    endfunction

    // One arbitration episode starting in an IDLE cycle (cycle 0). The model
    // lays out grant / access / done windows in time; second grant follows
    // the first one's DONE cycle.
    task automatic run_txn(input bit do_if, input logic [31:0] ia,
                           input bit mr, input bit mw, input logic [31:0] ma,
                           input logic [31:0] wd, input bit drop,
                           input bit use_fixed, input logic [31:0] fixed_rd);
        bit          do_mem;
        bit          first_data;
        int          g_if;
        int          g_mem;
        int          done_if;
        int          done_mem;
        int          last;
        bit          if_on;
        bit          mem_on;
        bit          acc_if;
        bit          acc_mem;
        bit          rdy_if;
        bit          rdy_mem;
        logic [31:0] rd_if;
        logic [31:0] rd_mem;
        do_mem = mr | mw;
        first_data = do_mem;
        if (do_if && do_mem) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_data = rr_data_wins;
`else
            first_data = 1'b1;
`endif
        end
        g_mem    = (do_if && do_mem && !first_data) ? int'(W) + 2 : 0;
        g_if     = (do_if && do_mem && first_data) ? int'(W) + 2 : 0;
        done_if  = g_if + int'(W) + 1;
        done_mem = g_mem + int'(W) + 1;
        last     = 0;
        if (do_if && done_if > last) last = done_if;
        if (do_mem && done_mem > last) last = done_mem;
        rd_if  = use_fixed ? fixed_rd : pattern(ia);
        rd_mem = use_fixed ? fixed_rd : pattern(ma);
        if_addr   = ia;
        mem_addr  = ma;
        mem_wdata = wd;
        for (int c = 0; c <= last; c++) begin
            if_on   = do_if && (drop ? (c <= g_if) : (c <= done_if));
            mem_on  = do_mem && (drop ? (c <= g_mem) : (c <= done_mem));
            acc_if  = do_if && c > g_if && c <= g_if + int'(W);
            acc_mem = do_mem && c > g_mem && c <= g_mem + int'(W);
            rdy_if  = do_if && c == done_if;
            rdy_mem = do_mem && c == done_mem;
            if_req   = if_on;
            mem_r_en = mem_on & mr;
            mem_w_en = mem_on & mw;
            if (acc_if && c == g_if + int'(W)) sram_rdata = rd_if;
            else if (acc_mem && c == g_mem + int'(W)) sram_rdata = rd_mem;
            else sram_rdata = $urandom();
            if (rdy_if) exp_if_rdata = rd_if;
            if (rdy_mem && !mw) exp_mem_rdata = rd_mem;
            @(negedge clk);
            chk("sram_en", 32'(sram_en), 32'(acc_if | acc_mem));
            chk("sram_we", 32'(sram_we), 32'(acc_mem & mw));
            if (acc_if) chk("sram_addr_if", 32'(sram_addr), {2'b00, ia[31:2]});
            if (acc_mem) chk("sram_addr_mem", 32'(sram_addr), {2'b00, ma[31:2]});
            if (acc_mem && mw) chk("sram_wdata", sram_wdata, wd);
            chk("if_ready", 32'(if_ready), 32'(rdy_if));
            chk("mem_ready", 32'(mem_ready), 32'(rdy_mem));
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("mem_rdata", mem_rdata, exp_mem_rdata);
            chk("freeze", 32'(freeze), 32'((if_on & ~rdy_if) | (mem_on & ~rdy_mem)));
            @(posedge clk);
            #1;
        end
        if (do_if && do_mem) rr_data_wins = ~first_data;
        if_req   = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          kind;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_wdata = '0;
        sram_rdata = '0;
        exp_if_rdata = '0;
        exp_mem_rdata = '0;
        rr_data_wins = 1'b1;

        // Reset state.
        @(posedge clk); @(negedge clk);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch with a known instruction word.
        run_txn(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hE3A0_1005);
        // Data write; mem_rdata must stay put.
        run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        // Conflict fetch vs data read.
        run_txn(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 32'h0);
        // Further conflicts exercise priority order.
        run_txn(1'b1, 32'h0000_0404, 1'b0, 1'b1, 32'h0000_0508, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_060C, 1'b1, 1'b0, 32'h0000_0703, 32'h0, 1'b0, 1'b0, 32'h0);
        // Read and write together behaves as a write.
        run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0812, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        // Requests dropped right after grant still complete.
        run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0900, 32'h0BAD_CAFE, 1'b1, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_0A01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset in the second access cycle of a write aborts it.
        mem_w_en = 1'b1; mem_addr = 32'h0000_0B00; mem_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_sram_en", 32'(sram_en), 32'd0);
        chk("abort_sram_we", 32'(sram_we), 32'd0);
        chk("abort_mem_ready", 32'(mem_ready), 32'd0);
        exp_if_rdata = '0;
        exp_mem_rdata = '0;
        rr_data_wins = 1'b1;
        chk("abort_if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        chk("abort_freeze", 32'(freeze), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_hold_en", 32'(sram_en), 32'd0);
        chk("abort_hold_ready", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0B00, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        // Priority pointer is back to data after reset.
        run_txn(1'b1, 32'h0000_0C00, 1'b1, 1'b0, 32'h0000_0D00, 32'h0, 1'b0, 1'b0, 32'h0);

        // Randomized episodes.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom();
            rb = $urandom();
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: run_txn(1'b1, ra, 1'b0, 1'b0, rb, 32'h0, $urandom_range(0, 1) == 1, 1'b0, 32'h0);
                1: run_txn(1'b0, ra, 1'b1, 1'b0, rb, 32'h0, $urandom_range(0, 1) == 1, 1'b0, 32'h0);
                2: run_txn(1'b0, ra, 1'b0, 1'b1, rb, $urandom(), $urandom_range(0, 1) == 1, 1'b0, 32'h0);
                3: run_txn(1'b1, ra, 1'b1, 1'b0, rb, 32'h0, 1'b0, 1'b0, 32'h0);
                4: run_txn(1'b1, ra, 1'b0, 1'b1, rb, $urandom(), 1'b0, 1'b0, 32'h0);
                default: run_txn(1'b1, ra, 1'b1, 1'b1, rb, $urandom(), 1'b0, 1'b0, 32'h0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
